// File: rtl/sbtx_frame_serializer.sv
// Sideband transmit framer/serializer: byte stream in, 10-bit symbols
// (start 0, 8 data bits LSB first, stop 1) out on sbtx, with optional
// CRC bytes appended after the last payload byte.
module sbtx_frame_serializer #(
    parameter int               CRC_W    = 16,
    parameter logic [CRC_W-1:0] POLY     = 16'h8005,
    parameter logic [CRC_W-1:0] INIT     = 16'hFFFF,
    parameter logic             IDLE_LVL = 1'b0
) (
    input  logic       sb_clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    input  logic       crc_en,
    output logic       in_ready,
    output logic       sbtx,
    output logic       busy,
    output logic       frame_done
);

    localparam int CRC_BYTES = CRC_W / 8;
    localparam int IDX_W     = (CRC_BYTES > 1) ? $clog2(CRC_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CRC_BYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_CRC  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       sh_q, sh_d;
    logic             last_q, last_d;
    logic             crcf_q, crcf_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [IDX_W-1:0] cidx_q, cidx_d;
    logic             sbtx_q, sbtx_d;
    logic             live_q;

    logic             accept;
    logic [2:0]       bi_q, bi_d;
    logic             fb;
    logic [7:0]       sym_byte_d;

    // Handshake, status and end-of-frame flags decoded from registered state
    always_comb begin
        in_ready   = live_q && ((state_q == S_IDLE) ||
                                (state_q == S_DATA && bit_cnt_q == 4'd9 && !last_q));
        accept     = in_valid && in_ready;
        busy       = (state_q != S_IDLE);
        frame_done = (state_q == S_DATA && bit_cnt_q == 4'd9 && last_q && !crcf_q) ||
                     (state_q == S_CRC  && bit_cnt_q == 4'd9 && cidx_q == LAST_IDX);
    end

    // Next-state, shift/CRC update, and the line bit for the next cycle
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sh_d       = sh_q;
        last_d     = last_q;
        crcf_d     = crcf_q;
        crc_d      = crc_q;
        cidx_d     = cidx_q;
        bi_q       = 3'(bit_cnt_q - 4'd1);
        fb         = sh_q[bi_q] ^ crc_q[CRC_W-1];
        bi_d       = 3'b0;
        sym_byte_d = 8'h00;
        sbtx_d     = IDLE_LVL;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sh_d      = in_data;
                    last_d    = in_last;
                    crcf_d    = crc_en;
                    crc_d     = INIT;
                    state_d   = S_DATA;
                    bit_cnt_d = 4'd0;
                end
            end
            S_DATA: begin
                if (bit_cnt_q != 4'd9) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q != 4'd0)
                        crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
                end else if (!last_q) begin
                    // Without a new byte we sit on the stop bit (mark) indefinitely
                    if (accept) begin
                        sh_d      = in_data;
                        last_d    = in_last;
                        bit_cnt_d = 4'd0;
                    end
                end else if (crcf_q) begin
                    state_d   = S_CRC;
                    bit_cnt_d = 4'd0;
                    cidx_d    = '0;
                end else begin
                    state_d   = S_IDLE;
                    bit_cnt_d = 4'd0;
                end
            end
            S_CRC: begin
                if (bit_cnt_q != 4'd9) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (cidx_q == LAST_IDX) begin
                    state_d   = S_IDLE;
                    bit_cnt_d = 4'd0;
                    cidx_d    = '0;
                end else begin
                    cidx_d    = cidx_q + IDX_W'(1);
                    bit_cnt_d = 4'd0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                bit_cnt_d = 4'd0;
            end
        endcase

        // sbtx is registered, so it is derived from the next-cycle state
        if (state_d == S_CRC) begin
            for (int unsigned k = 0; k < CRC_BYTES; k++)
                if (cidx_d == IDX_W'(k))
                    sym_byte_d = crc_d[CRC_W-1-8*k -: 8];
        end else begin
            sym_byte_d = sh_d;
        end
        bi_d = 3'(bit_cnt_d - 4'd1);
        if (state_d == S_IDLE)
            sbtx_d = IDLE_LVL;
        else if (bit_cnt_d == 4'd0)
            sbtx_d = 1'b0;
        else if (bit_cnt_d == 4'd9)
            sbtx_d = 1'b1;
        else
            sbtx_d = sym_byte_d[bi_d];
    end

    // State registers; live_q keeps in_ready low until the first clock after reset
    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 4'd0;
            sh_q      <= 8'h00;
            last_q    <= 1'b0;
            crcf_q    <= 1'b0;
            crc_q     <= INIT;
            cidx_q    <= '0;
            sbtx_q    <= 1'b0;
            live_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            last_q    <= last_d;
            crcf_q    <= crcf_d;
            crc_q     <= crc_d;
            cidx_q    <= cidx_d;
            sbtx_q    <= sbtx_d;
            live_q    <= 1'b1;
        end
    end

    assign sbtx = sbtx_q;

endmodule

// File: tb/tb_sbtx_frame_serializer.sv
// Bench for sbtx_frame_serializer: two instances (INIT=FFFF and INIT=0000)
// share one stimulus; a bit-level model fills per-instance expectation queues.
module tb_sbtx_frame_serializer;

    localparam logic IDLE_LVL = 1'b0;

    logic       sb_clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       crc_en;
    logic       in_ready_a, sbtx_a, busy_a, frame_done_a;
    logic       in_ready_b, sbtx_b, busy_b, frame_done_b;

    always #5 sb_clk = ~sb_clk;

    sbtx_frame_serializer #(.CRC_W(16), .POLY(16'h8005), .INIT(16'hFFFF), .IDLE_LVL(IDLE_LVL)) u_a (
        .sb_clk(sb_clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .crc_en(crc_en), .in_ready(in_ready_a), .sbtx(sbtx_a),
        .busy(busy_a), .frame_done(frame_done_a)
    );

    sbtx_frame_serializer #(.CRC_W(16), .POLY(16'h8005), .INIT(16'h0000), .IDLE_LVL(IDLE_LVL)) u_b (
        .sb_clk(sb_clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .crc_en(crc_en), .in_ready(in_ready_b), .sbtx(sbtx_b),
        .busy(busy_b), .frame_done(frame_done_b)
    );

    int         vecs = 0;
    int         miss = 0;
    logic [1:0] qa[$];
    logic [1:0] qb[$];
    bit         mon_en = 1'b0;
    int         rdy_cnt;
    logic [29:0] cap_b;
    logic [7:0] fbytes[16];
    int         gaps[16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
        logic f;
        f = d ^ c[15];
        return {c[14:0], 1'b0} ^ (f ? 16'h8005 : 16'h0000);
    endfunction

    task automatic push_sym(input logic [7:0] b, input bit done, input bit to_b);
        logic [1:0] s;
        for (int j = 0; j < 10; j++) begin
            if (j == 0)      s = 2'b00;
            else if (j == 9) s = {done, 1'b1};
            else             s = {1'b0, b[j-1]};
            if (to_b) qb.push_back(s); else qa.push_back(s);
        end
    endtask

    task automatic model_frame(input int n, input bit ce);
        logic [15:0] c;
        for (int inst = 0; inst < 2; inst++) begin
            c = (inst == 1) ? 16'h0000 : 16'hFFFF;
            for (int i = 0; i < n; i++) begin
                push_sym(fbytes[i], (i == n-1) && !ce, inst == 1);
                for (int j = 0; j < 8; j++) c = crc_step(c, fbytes[i][j]);
                if (i < n-1)
                    for (int g = 0; g < gaps[i]; g++)
                        if (inst == 1) qb.push_back(2'b01); else qa.push_back(2'b01);
            end
            if (ce) begin
                push_sym(c[15:8], 1'b0, inst == 1);
                push_sym(c[7:0],  1'b1, inst == 1);
            end
        end
    endtask

    // Scoreboard: every busy cycle consumes one expected {frame_done, sbtx}
    always @(negedge sb_clk) begin
        if (mon_en) begin
            if (busy_a) begin
                if (qa.size() == 0) chk("a_busy_unexpected", busy_a, 0);
                else chk("a_line", {frame_done_a, sbtx_a}, qa.pop_front());
                if (in_ready_a) rdy_cnt++;
            end else begin
                chk("a_done_when_idle", frame_done_a, 0);
            end
            if (busy_b) begin
                if (qb.size() == 0) chk("b_busy_unexpected", busy_b, 0);
                else chk("b_line", {frame_done_b, sbtx_b}, qb.pop_front());
                cap_b = {cap_b[28:0], sbtx_b};
            end else begin
                chk("b_done_when_idle", frame_done_b, 0);
            end
        end
    end

    task automatic send_frame(input int n, input bit ce);
        int g;
        int waited;
        bit ok;
        model_frame(n, ce);
        rdy_cnt = 0;
        ok = 1'b1;
        for (int i = 0; i < n && ok; i++) begin
            in_data  = fbytes[i];
            in_last  = (i == n-1);
            crc_en   = (i == 0) ? ce : 1'($urandom % 2);
            g        = (i == 0) ? 0 : gaps[i-1];
            in_valid = (g == 0);
            waited   = 0;
            while (1) begin
                if (in_ready_a) begin
                    if (g == 0) begin
                        in_valid = 1'b1;
                        break;
                    end
                    g--;
                end
                @(negedge sb_clk);
                waited++;
                if (waited > 300) begin
                    chk("accept_timeout", in_ready_a, 1);
                    ok = 1'b0;
                    break;
                end
            end
            if (ok) @(negedge sb_clk);
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        waited   = 0;
        while ((qa.size() != 0 || qb.size() != 0) && waited < 400) begin
            @(negedge sb_clk);
            waited++;
        end
        chk("frame_drain_a", qa.size(), 0);
        chk("frame_drain_b", qb.size(), 0);
        qa.delete();
        qb.delete();
        @(negedge sb_clk);
        chk("post_busy_a", busy_a, 0);
        chk("post_sbtx_a", sbtx_a, IDLE_LVL);
        chk("post_ready_a", in_ready_a, 1);
        chk("post_busy_b", busy_b, 0);
    endtask

    initial begin
        int w;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; crc_en = 1'b0;
        for (int i = 0; i < 16; i++) gaps[i] = 0;
        #2 rst = 1'b0;
        #10;
        chk("rst_sbtx", sbtx_a, 0);
        chk("rst_ready", in_ready_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", frame_done_a, 0);
        @(negedge sb_clk) rst = 1'b1;
        @(negedge sb_clk);
        chk("rel_sbtx", sbtx_a, IDLE_LVL);
        chk("rel_ready", in_ready_a, 1);
        mon_en = 1'b1;

        // Single byte, no CRC
        fbytes[0] = 8'h01;
        send_frame(1, 1'b0);
        chk("single_ready_pulses", rdy_cnt, 0);

        // Single byte with CRC; INIT=0 instance must carry 01, 83, 03
        cap_b = '0;
        send_frame(1, 1'b1);
        chk("crc_init0_line", cap_b, 30'b0100000001_0110000011_0110000001);

        // Three bytes back to back
        fbytes[0] = 8'hA5; fbytes[1] = 8'h3C; fbytes[2] = 8'hFF;
        send_frame(3, 1'b0);
        chk("b2b_ready_pulses", rdy_cnt, 2);

        // Five-cycle stall after the first byte, CRC on
        fbytes[0] = 8'h5A; fbytes[1] = 8'hC3; gaps[0] = 5;
        send_frame(2, 1'b1);
        gaps[0] = 0;

        // Reset at bit 4 of the second byte
        mon_en = 1'b0;
        in_data = 8'h11; in_last = 1'b0; crc_en = 1'b1; in_valid = 1'b1;
        @(negedge sb_clk);
        in_data = 8'h22; in_last = 1'b1;
        w = 0;
        while (!in_ready_a && w < 50) begin
            @(negedge sb_clk);
            w++;
        end
        chk("mid_ready_seen", in_ready_a, 1);
        @(negedge sb_clk);
        in_valid = 1'b0;
        repeat (4) @(negedge sb_clk);
        chk("mid_busy_before", busy_a, 1);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_sbtx", sbtx_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_done", frame_done_a, 0);
        chk("mid_rst_ready", in_ready_a, 0);
        @(negedge sb_clk) rst = 1'b1;
        @(negedge sb_clk);
        chk("mid_rel_sbtx", sbtx_a, IDLE_LVL);
        chk("mid_rel_ready", in_ready_a, 1);
        qa.delete(); qb.delete();
        mon_en = 1'b1;
        fbytes[0] = 8'h01; fbytes[1] = 8'h80;
        send_frame(2, 1'b1);

        // Random frames against the model
        for (int f = 0; f < 250; f++) begin
            int n;
            n = int'($urandom_range(1, 16));
            for (int i = 0; i < n; i++) begin
                fbytes[i] = 8'($urandom);
                gaps[i]   = ($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0;
            end
            send_frame(n, 1'($urandom % 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
